// File: rtl/chess_pkg.sv
// chess_pkg: shared types for the cursor/move-selection controller.
package chess_pkg;
  typedef enum logic [1:0] {SEL_SRC, SEL_DST, REQ} ctrl_state_t;
  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } square_t;
  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_SEL} dir_t;
endpackage

// File: rtl/cursor_controller_if.sv
// cursor_controller_if: buttons, cursor/source outputs and the move req/ack handshake.
interface cursor_controller_if;
  logic btn_up, btn_down, btn_left, btn_right, btn_sel, move_ack;
  logic [2:0] cursor_row, cursor_col, src_row, src_col;
  logic src_valid, move_req;
  logic [5:0] move_from, move_to;
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, move_ack,
    input cursor_row, cursor_col, src_valid, src_row, src_col, move_req, move_from, move_to
  );
  modport slave (
    input btn_up, btn_down, btn_left, btn_right, btn_sel, move_ack,
    output cursor_row, cursor_col, src_valid, src_row, src_col, move_req, move_from, move_to
  );
endinterface

// File: rtl/cursor_controller_button_sync.sv
// button_sync: 2-flop synchronizer followed by a rising-edge detector.
module button_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic s1, s2, prev;
  always_ff @(posedge clk)
    if (reset) {s1, s2, prev} <= '0;
    else {s1, s2, prev} <= {btn, s1, s2};
  assign pulse = s2 & ~prev;
endmodule

// File: rtl/cursor_controller.sv
// cursor_controller: arbitrated button events drive the cursor and the src/dst move-selection FSM.
module cursor_controller
  import chess_pkg::*;
#(
  parameter int unsigned LOCKOUT = 16
) (
  input logic clk,
  input logic reset,
  cursor_controller_if.slave bus
);
  localparam int LW = LOCKOUT > 0 ? $clog2(LOCKOUT + 1) : 1;
  logic [4:0] raw, p;
  dir_t dir;
  logic go, src_valid, req;
  logic [LW-1:0] lock;
  ctrl_state_t state;
  square_t cur, src, from, to;
  assign raw = {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_sync u_sync (.clk(clk), .reset(reset), .btn(raw[i]), .pulse(p[i]));
  end
  always_comb
    dir = p[0] ? DIR_UP : p[1] ? DIR_DOWN : p[2] ? DIR_LEFT :
          p[3] ? DIR_RIGHT : p[4] ? DIR_SEL : DIR_NONE;
  // Events in REQ are dropped without touching lockout.
  assign go = dir != DIR_NONE && lock == '0 && state != REQ;
  always_ff @(posedge clk)
    if (reset) begin
      lock <= '0;
      state <= SEL_SRC;
      cur <= '0;
      src <= '0;
      from <= '0;
      to <= '0;
      src_valid <= 1'b0;
      req <= 1'b0;
    end else begin
      lock <= go ? LW'(LOCKOUT) : lock != '0 ? lock - LW'(1) : lock;
      if (go && dir == DIR_UP) cur.row <= cur.row - 3'd1;
      if (go && dir == DIR_DOWN) cur.row <= cur.row + 3'd1;
      if (go && dir == DIR_LEFT) cur.col <= cur.col - 3'd1;
      if (go && dir == DIR_RIGHT) cur.col <= cur.col + 3'd1;
      if (go && dir == DIR_SEL) begin
        if (state == SEL_SRC) begin
          src <= cur;
          src_valid <= 1'b1;
          state <= SEL_DST;
        end else if (cur == src) begin
          src <= '0;
          src_valid <= 1'b0;
          state <= SEL_SRC;
        end else begin
          from <= src;
          to <= cur;
          req <= 1'b1;
          state <= REQ;
        end
      end
      if (state == REQ && bus.move_ack) begin
        req <= 1'b0;
        src <= '0;
        src_valid <= 1'b0;
        state <= SEL_SRC;
      end
    end
  assign bus.cursor_row = cur.row;
  assign bus.cursor_col = cur.col;
  assign bus.src_valid = src_valid;
  assign bus.src_row = src.row;
  assign bus.src_col = src.col;
  assign bus.move_req = req;
  assign bus.move_from = from;
  assign bus.move_to = to;
endmodule

// File: tb/tb_cursor_controller.sv
// tb_cursor_controller: directed presses with a queued-expectation scoreboard and output-change monitor.
module tb_cursor_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  cursor_controller_if bus ();
  cursor_controller #(.LOCKOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] r, c;
    logic sv;
    logic [2:0] sr, sc;
    logic rq;
    logic [5:0] f, t;
  } snap_t;
  typedef struct {
    int unsigned at;
    snap_t s;
  } exp_t;
  localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LF = 5'b00100, RT = 5'b01000, SL = 5'b10000;
  exp_t q[$];
  int unsigned cyc = 0;
  int checks = 0, errors = 0;
  bit probe = 1'b0;
  snap_t prev = '0;
  snap_t cur_s;
  assign cur_s = {bus.cursor_row, bus.cursor_col, bus.src_valid, bus.src_row, bus.src_col,
                  bus.move_req, bus.move_from, bus.move_to};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (cur_s !== prev || probe) begin : mon
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h want=no change", cyc, cur_s);
      end else begin
        e = q.pop_front();
        if (e.s !== cur_s || e.at != cyc) begin
          errors++;
          $display("FAIL outputs cyc=%0d got=%h want=%h at cyc %0d", cyc, cur_s, e.s, e.at);
        end
      end
      prev = cur_s;
      probe = 1'b0;
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic exp_at(input int unsigned at, input logic [2:0] r, c, input logic sv,
                        input logic [2:0] sr, sc, input logic rq, input logic [5:0] f, t);
    exp_t e;
    e.at = at;
    e.s = {r, c, sv, sr, sc, rq, f, t};
    q.push_back(e);
  endtask
  task automatic press(input logic [4:0] m);
    {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = m;
    tick(1);
    {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = '0;
  endtask
  initial begin
    {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = '0;
    bus.move_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    exp_at(cyc, 0, 0, 0, 0, 0, 0, 0, 0);
    probe = 1'b1;
    tick(2);
    exp_at(cyc + 3, 7, 0, 0, 0, 0, 0, 0, 0);
    press(UP);
    tick(1);
    press(UP);
    tick(6);
    exp_at(cyc + 3, 6, 0, 0, 0, 0, 0, 0, 0);
    press(UP);
    tick(6);
    for (int i = 1; i <= 8; i++) begin
      exp_at(cyc + 3, 6, 3'(i), 0, 0, 0, 0, 0, 0);
      press(RT);
      tick(6);
    end
    reset = 1'b1;
    exp_at(cyc + 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1);
    reset = 1'b0;
    tick(2);
    exp_at(cyc + 3, 7, 0, 0, 0, 0, 0, 0, 0);
    press(UP | RT);
    tick(6);
    for (int i = 1; i <= 4; i++) begin
      exp_at(cyc + 3, 3'(7 - i), 0, 0, 0, 0, 0, 0, 0);
      press(UP);
      tick(6);
    end
    for (int i = 1; i <= 4; i++) begin
      exp_at(cyc + 3, 3, 3'(i), 0, 0, 0, 0, 0, 0);
      press(RT);
      tick(6);
    end
    exp_at(cyc + 3, 3, 4, 1, 3, 4, 0, 0, 0);
    press(SL);
    tick(6);
    exp_at(cyc + 3, 4, 4, 1, 3, 4, 0, 0, 0);
    press(DN);
    tick(6);
    exp_at(cyc + 3, 5, 4, 1, 3, 4, 0, 0, 0);
    press(DN);
    tick(6);
    exp_at(cyc + 3, 5, 4, 1, 3, 4, 1, 6'o34, 6'o54);
    press(SL);
    tick(6);
    press(UP);
    tick(6);
    press(LF);
    tick(6);
    exp_at(cyc, 5, 4, 1, 3, 4, 1, 6'o34, 6'o54);
    probe = 1'b1;
    tick(1);
    bus.move_ack = 1'b1;
    exp_at(cyc + 1, 5, 4, 0, 0, 0, 0, 6'o34, 6'o54);
    tick(1);
    bus.move_ack = 1'b0;
    tick(2);
    for (int i = 1; i <= 3; i++) begin
      exp_at(cyc + 3, 3'(5 - i), 4, 0, 0, 0, 0, 6'o34, 6'o54);
      press(UP);
      tick(6);
    end
    for (int i = 1; i <= 2; i++) begin
      exp_at(cyc + 3, 2, 3'(4 - i), 0, 0, 0, 0, 6'o34, 6'o54);
      press(LF);
      tick(6);
    end
    exp_at(cyc + 3, 2, 2, 1, 2, 2, 0, 6'o34, 6'o54);
    press(SL);
    tick(6);
    exp_at(cyc + 3, 2, 2, 0, 0, 0, 0, 6'o34, 6'o54);
    press(SL);
    tick(6);
    exp_at(cyc + 3, 2, 2, 1, 2, 2, 0, 6'o34, 6'o54);
    press(SL);
    tick(6);
    exp_at(cyc + 3, 2, 3, 1, 2, 2, 0, 6'o34, 6'o54);
    press(RT);
    tick(6);
    exp_at(cyc + 3, 2, 3, 1, 2, 2, 1, 6'o22, 6'o23);
    press(SL);
    tick(6);
    reset = 1'b1;
    exp_at(cyc + 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1);
    reset = 1'b0;
    tick(1);
    bus.move_ack = 1'b1;
    tick(1);
    bus.move_ack = 1'b0;
    tick(2);
    exp_at(cyc, 0, 0, 0, 0, 0, 0, 0, 0);
    probe = 1'b1;
    tick(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got=%0d left want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
